// File: rtl/axis_job_ctrl.sv
// Job front-end for the AXI stream DMA core: turns (dir, addr, len) jobs into three cfg beats and tracks per-direction completion.
// Optional stray-beat detection is enabled by defining AXIS_JOB_CTRL_ERR_EN.
module axis_job_ctrl #(
  parameter int CFG_ID_WR  = 1,
  parameter int CFG_ID_RD  = 2,
  parameter int CFG_ADDR   = 23,
  parameter int CFG_DATA   = 24,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic                  job_dir,
  input  logic [CFG_DWIDTH-1:0] job_addr,
  input  logic [CFG_DWIDTH-1:0] job_len,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  wr_beat,
  input  logic                  rd_beat,
  output logic                  wr_busy,
  output logic                  rd_busy,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  err_stray
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] ADR  = 2'd2;
  localparam logic [1:0] LEN  = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic                        dir_q, dir_d;
  logic [CFG_DWIDTH-1:0]       addr_q, addr_d;
  logic [1:0]                  busy_q, busy_d;
  logic [1:0]                  done_q, done_d;
  logic [1:0][CFG_DWIDTH-1:0]  cnt_q, cnt_d;
  logic [1:0][CFG_DWIDTH-1:0]  tgt_q, tgt_d;
  logic                        cfg_valid_q, cfg_valid_d;
  logic [CFG_AWIDTH-1:0]       cfg_addr_q, cfg_addr_d;
  logic [CFG_DWIDTH-1:0]       cfg_data_q, cfg_data_d;
  logic [1:0]                  beat;
  logic                        accept;

  assign job_ready = (state_q == IDLE) && !rst && !busy_q[job_dir];
  assign accept    = job_valid && job_ready;
  assign beat      = {rd_beat, wr_beat};

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;

    // Beats only count while the direction is busy; the last one retires the job.
    for (int d = 0; d < 2; d++) begin
      if (beat[d] && busy_q[d]) begin
        cnt_d[d] = cnt_q[d] + CFG_DWIDTH'(1);
        if (cnt_q[d] + CFG_DWIDTH'(1) == tgt_q[d]) begin
          busy_d[d] = 1'b0;
          done_d[d] = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d           = job_dir;
          addr_d          = job_addr;
          cnt_d[job_dir]  = '0;
          tgt_d[job_dir]  = job_len;
          if (job_len == '0) begin
            done_d[job_dir] = 1'b1;
          end else begin
            busy_d[job_dir] = 1'b1;
            state_d         = SEL;
          end
        end
      end
      SEL:     state_d = ADR;
      ADR:     state_d = LEN;
      LEN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The cfg bus is registered, so the beat is built from the state being entered.
  always_comb begin
    cfg_valid_d = (state_d != IDLE);
    cfg_addr_d  = '0;
    cfg_data_d  = '0;
    case (state_d)
      SEL: cfg_addr_d = dir_d ? CFG_AWIDTH'(CFG_ID_RD) : CFG_AWIDTH'(CFG_ID_WR);
      ADR: begin
        cfg_addr_d = CFG_AWIDTH'(CFG_ADDR);
        cfg_data_d = addr_d;
      end
      LEN: begin
        cfg_addr_d = CFG_AWIDTH'(CFG_DATA);
        cfg_data_d = tgt_d[dir_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      addr_q      <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      cnt_q       <= '0;
      tgt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign wr_busy   = busy_q[0];
  assign rd_busy   = busy_q[1];
  assign wr_done   = done_q[0];
  assign rd_done   = done_q[1];

`ifdef AXIS_JOB_CTRL_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q | (wr_beat & ~busy_q[0]) | (rd_beat & ~busy_q[1]);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_stray = err_q;
`else
  assign err_stray = 1'b0;
`endif

endmodule

// File: tb/tb_axis_job_ctrl.sv
// Self-checking bench for axis_job_ctrl: queue/counter reference model compared every cycle, plus directed literal checks.
// Honours AXIS_JOB_CTRL_ERR_EN the same way as the design.
module tb_axis_job_ctrl;

`ifdef AXIS_JOB_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic        job_dir = 1'b0;
  logic [31:0] job_addr = '0;
  logic [31:0] job_len = '0;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        wr_beat = 1'b0;
  logic        rd_beat = 1'b0;
  logic        wr_busy, rd_busy, wr_done, rd_done, err_stray;

  axis_job_ctrl dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_dir(job_dir),
    .job_addr(job_addr), .job_len(job_len),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .wr_beat(wr_beat), .rd_beat(rd_beat),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_done(wr_done), .rd_done(rd_done),
    .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } cfg_beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Model: pending cfg beats as a queue, outstanding work as remaining-beat counts.
  cfg_beat_t       cfg_fifo[$];
  longint unsigned left[2];
  logic        exp_cfg_valid, nxt_cfg_valid;
  logic [4:0]  exp_cfg_addr, nxt_cfg_addr;
  logic [31:0] exp_cfg_data, nxt_cfg_data;
  logic [1:0]  exp_busy, nxt_busy, exp_done, nxt_done;
  logic        exp_err, nxt_err, exp_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit jv, input bit jd, input logic [31:0] ja,
                                input logic [31:0] jl, input bit wb, input bit rb);
    logic [1:0] bts;
    cfg_beat_t  b;
    @(posedge clk);
    #1;
    exp_cfg_valid = nxt_cfg_valid;
    exp_cfg_addr  = nxt_cfg_addr;
    exp_cfg_data  = nxt_cfg_data;
    exp_busy      = nxt_busy;
    exp_done      = nxt_done;
    exp_err       = nxt_err;

    rst = r; job_valid = jv; job_dir = jd; job_addr = ja; job_len = jl;
    wr_beat = wb; rd_beat = rb;
    exp_ready = !r && !exp_cfg_valid && (left[jd] == 0);

    if (r) begin
      left[0] = 0; left[1] = 0;
      cfg_fifo.delete();
      nxt_done = '0;
      nxt_err  = 1'b0;
    end else begin
      nxt_done = '0;
      bts = {rb, wb};
      for (int d = 0; d < 2; d++) begin
        if (bts[d]) begin
          if (left[d] == 0) begin
            nxt_err = nxt_err | ERR_EN;
          end else begin
            left[d]--;
            if (left[d] == 0) nxt_done[d] = 1'b1;
          end
        end
      end
      if (jv && exp_ready) begin
        if (jl == 0) begin
          nxt_done[jd] = 1'b1;
        end else begin
          left[jd] = jl;
          b.addr = jd ? 5'd2 : 5'd1;  b.data = '0; cfg_fifo.push_back(b);
          b.addr = 5'd23;             b.data = ja; cfg_fifo.push_back(b);
          b.addr = 5'd24;             b.data = jl; cfg_fifo.push_back(b);
        end
      end
    end
    nxt_busy = {left[1] != 0, left[0] != 0};
    if (cfg_fifo.size() > 0) begin
      b = cfg_fifo.pop_front();
      nxt_cfg_valid = 1'b1; nxt_cfg_addr = b.addr; nxt_cfg_data = b.data;
    end else begin
      nxt_cfg_valid = 1'b0; nxt_cfg_addr = '0; nxt_cfg_data = '0;
    end
    #1;
  endtask

  task automatic idle(input bit wb, input bit rb);
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, wb, rb);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("cfg_valid", cfg_valid, exp_cfg_valid);
      check("cfg_addr",  cfg_addr,  exp_cfg_addr);
      check("cfg_data",  cfg_data,  exp_cfg_data);
      check("busy",      {rd_busy, wr_busy}, exp_busy);
      check("done",      {rd_done, wr_done}, exp_done);
      check("err_stray", err_stray, exp_err);
      check("job_ready", job_ready, exp_ready);
    end
  end

  initial begin
    left[0] = 0; left[1] = 0;
    nxt_cfg_valid = 0; nxt_cfg_addr = '0; nxt_cfg_data = '0;
    nxt_busy = '0; nxt_done = '0; nxt_err = 1'b0;

    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 32'd3, 1'b0, 1'b0);
    checking = 1'b1;
    check("reset_ready", job_ready, 1'b0);
    check("reset_cfg_valid", cfg_valid, 1'b0);
    check("reset_busy", {rd_busy, wr_busy}, 2'b00);

    // Write job, len 4
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'd4, 1'b0, 1'b0);
    check("wr_accept_ready", job_ready, 1'b1);
    idle(1'b1, 1'b0);
    check("sel_addr", cfg_addr, 5'd1);
    check("sel_data", cfg_data, 32'd0);
    check("sel_busy", wr_busy, 1'b1);
    check("sel_ready", job_ready, 1'b0);
    idle(1'b1, 1'b0);
    check("adr_addr", cfg_addr, 5'd23);
    check("adr_data", cfg_data, 32'h1000_0000);
    idle(1'b1, 1'b0);
    check("len_addr", cfg_addr, 5'd24);
    check("len_data", cfg_data, 32'd4);
    idle(1'b1, 1'b0);
    check("post_cfg_valid", cfg_valid, 1'b0);
    check("pre_done_busy", wr_busy, 1'b1);
    idle(1'b0, 1'b0);
    check("wr_done", wr_done, 1'b1);
    check("wr_busy_low", wr_busy, 1'b0);
    idle(1'b0, 1'b0);
    check("wr_done_one_cycle", wr_done, 1'b0);

    // Zero-length read
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h55, 32'd0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("zl_done", rd_done, 1'b1);
    check("zl_busy", rd_busy, 1'b0);
    check("zl_cfg_valid", cfg_valid, 1'b0);
    idle(1'b0, 1'b0);
    check("zl_done_clear", rd_done, 1'b0);

    // Concurrent directions plus busy blocking
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hA0, 32'd3, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hB0, 32'd9, 1'b0, 1'b0);
    check("busy_block", job_ready, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hC0, 32'd2, 1'b0, 1'b0);
    check("other_dir_ready", job_ready, 1'b1);
    idle(1'b1, 1'b1);
    check("rd_sel_addr", cfg_addr, 5'd2);
    check("both_busy", {rd_busy, wr_busy}, 2'b11);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    check("both_done", {rd_done, wr_done}, 2'b11);
    check("both_idle", {rd_busy, wr_busy}, 2'b00);

    // Reset during the ADR beat
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hD0, 32'd5, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("abort_at_adr", cfg_addr, 5'd23);
    idle(1'b0, 1'b0);
    check("abort_cfg_valid", cfg_valid, 1'b0);
    check("abort_busy", wr_busy, 1'b0);
    check("abort_done", wr_done, 1'b0);

    // Stray beat, then a len-1 job proves the counter was untouched
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check("stray_err", err_stray, ERR_EN);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'hE0, 32'd1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    check("len1_done", wr_done, 1'b1);
    check("stray_sticky", err_stray, ERR_EN);

    // Maximum length is carried unchanged and does not complete early
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check("max_len_data", cfg_data, 32'hFFFF_FFFF);
    idle(1'b0, 1'b1);
    check("max_len_busy", rd_busy, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] len;
      len = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
      apply_stimulus($urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                     $urandom, len, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    @(posedge clk);
    #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_job_ctrl.md
# axis_job_ctrl

Job front-end for the AXI stream DMA core. Accepts transfer jobs (direction, start address, length) over a valid/ready handshake and serialises each into the three-beat configuration write sequence consumed by the core's `cfg_addr`/`cfg_data`/`cfg_valid` bus. It then counts stream-side handshakes to detect completion, reporting per-direction busy and done status to the host logic. It sits directly upstream of the DMA core's configuration port.

## Interface

Parameters:
- CFG_ID_WR, 1: cfg address selecting the write engine
- CFG_ID_RD, 2: cfg address selecting the read engine
- CFG_ADDR, 23: cfg address carrying start address
- CFG_DATA, 24: cfg address carrying length in stream words
- CFG_AWIDTH, 5: cfg address width
- CFG_DWIDTH, 32: cfg data width; also job address, length and counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when high with job_valid
- job_dir  in  1  0 = write (stream to memory), 1 = read
- job_addr  in  CFG_DWIDTH  byte start address
- job_len  in  CFG_DWIDTH  length in stream words
- cfg_addr  out  CFG_AWIDTH  cfg register address
- cfg_data  out  CFG_DWIDTH  cfg register data
- cfg_valid  out  1  cfg beat strobe (no backpressure)
- wr_beat  in  1  write-stream handshake (wr_valid & wr_ready)
- rd_beat  in  1  read-stream handshake (rd_valid & rd_ready)
- wr_busy, rd_busy  out  1 each  job outstanding per direction
- wr_done, rd_done  out  1 each  one-cycle completion pulse
- err_stray  out  1  sticky: stream beat seen with no job outstanding

## Operation

- FSM states: IDLE, SEL, ADR, LEN.
  - IDLE -> SEL on job accept when job_len != 0.
  - Then SEL -> ADR -> LEN -> IDLE unconditionally, one cycle each.
- job_ready = (state == IDLE) && !rst && !busy[job_dir].
  - Combinational on job_dir.
  - Job fields are latched on accept.
- Beat contents:
  - SEL: cfg_addr = job_dir ? CFG_ID_RD : CFG_ID_WR, cfg_data = 0.
  - ADR: cfg_addr = CFG_ADDR, cfg_data = job_addr.
  - LEN: cfg_addr = CFG_DATA, cfg_data = job_len.
  - cfg_valid is high only in SEL/ADR/LEN.
- Zero-length job:
  - Accepted.
  - No cfg beats are emitted and the FSM stays in IDLE.
  - done[dir] pulses the cycle after accept; busy never rises.
- Per-direction completion counter (CFG_DWIDTH bits):
  - Cleared on accept.
  - Increments on beat while busy.
  - When beat && (cnt + 1 == len): done pulses next cycle and busy clears on that same cycle.
- Directions are independent:
  - Both may be busy at once.
  - Both done pulses may coincide.
  - The cfg sequencer serialises job acceptance only.
- A beat arriving for a direction whose busy is low is ignored by the counter.

## Timing

- Reset values:
  - cfg_valid = 0, cfg_addr = 0, cfg_data = 0.
  - busy = 0, done = 0, err_stray = 0, job_ready = 0.
  - FSM = IDLE, counters = 0.
- All outputs except job_ready are registered.
- Accept at cycle T:
  - cfg beats at T+1 (SEL), T+2 (ADR), T+3 (LEN).
  - busy[dir] high from T+1.
  - job_ready low T+1..T+3 and high again at T+4 if the offered dir is not busy.
- Stream beats are counted from T+1 onward, including cycles where cfg is still streaming.
- Last counted beat at cycle B: done high at B+1 for exactly one cycle, busy low at B+1.
  - A new job of the same dir can be accepted at B+1.
- Counter comparison is against the full latched length; no wrap. job_len = 2^CFG_DWIDTH-1 is legal.
- rst mid-sequence:
  - Next cycle: all state returns to reset values, a partial cfg sequence is abandoned, and no done pulse is generated.

## Configuration

- Macro AXIS_JOB_CTRL_ERR_EN.
- Defined:
  - err_stray sets on wr_beat && !wr_busy, or rd_beat && !rd_busy.
  - It is sticky until rst.
- Undefined:
  - err_stray is tied to 0 and the detection logic is absent.
  - All other behaviour is identical.

## Test plan

- **Write job:** write job addr=0x1000_0000, len=4 -> cfg beats (1,0), (23,0x10000000), (24,4) on T+1..T+3; wr_busy at T+1; 4 wr_beats -> wr_done one cycle after 4th beat, wr_busy low same cycle.
- **Zero length:** read job len=0 -> no cfg_valid, rd_done at T+1, rd_busy stays 0.
- **Concurrent directions:** write len=3 then read len=2 accepted at T+4 -> read SEL beat uses addr 2; beats on both sides simultaneous -> both dones pulse same cycle when both reach their length.
- **Busy block:** write job while wr_busy -> job_ready=0; a read job offered the same cycle -> job_ready=1.
- **Reset abort:** rst asserted at ADR beat -> next cycle cfg_valid=0, busy=0, no done; subsequent job proceeds normally.
- **Stray beat:** wr_beat with no job -> err_stray=1 held (macro defined), 0 (undefined); counter unaffected.
